// File: rtl/dec_onehot_seq_if.sv
// Select/decode bundle between a controller (master) and the one-hot decoder (slave).
// Carries the valid/ready select handshake plus the registered decode outputs.
interface dec_onehot_seq_if #(
  parameter int SEL_W = 2,
  parameter int OUT_N = 4
) ();
  logic             en;
  logic [1:0]       mode;
  logic [SEL_W-1:0] sel;
  logic             sel_valid;
  logic             sel_ready;
  logic [OUT_N-1:0] dec_out;
  logic             busy;
  logic             err;

  modport master (
    output en, mode, sel, sel_valid,
    input  sel_ready, dec_out, busy, err
  );

  modport slave (
    input  en, mode, sel, sel_valid,
    output sel_ready, dec_out, busy, err
  );
endinterface

// File: rtl/dec_onehot_seq.sv
// Registered binary-to-one-hot decoder with LEVEL, timed PULSE and autonomous SCAN modes.
// Drives chip-selects for OUT_N downstream channels; dec_out is never multi-hot.
module dec_onehot_seq #(
  parameter int SEL_W     = 2,
  parameter int OUT_N     = 4,
  parameter int PULSE_LEN = 1,
  parameter int DWELL     = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  dec_onehot_seq_if.slave    bus
);

  localparam int CNT_MAX = (PULSE_LEN > DWELL) ? PULSE_LEN : DWELL;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = $clog2(OUT_N);

  localparam logic [1:0] MODE_PULSE = 2'b01;
  localparam logic [1:0] MODE_SCAN  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LEVEL,
    S_PULSE,
    S_SCAN
  } state_e;

  state_e           state_q, state_d;
  logic [OUT_N-1:0] dec_q, dec_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic             accept;
  logic             selInRange;
  logic [IDX_W-1:0] idxNext;

  function automatic logic [OUT_N-1:0] onehot(input int k);
    logic [OUT_N-1:0] r;
    for (int i = 0; i < OUT_N; i++) begin
      r[i] = (k == i);
    end
    return r;
  endfunction

  assign selInRange    = int'(bus.sel) < OUT_N;
  assign bus.sel_ready = bus.en && (state_q == S_IDLE || state_q == S_LEVEL) &&
                         (bus.mode != MODE_SCAN);
  assign accept        = bus.sel_valid && bus.sel_ready;
  assign bus.busy      = (state_q == S_PULSE) || (state_q == S_SCAN);
  assign bus.dec_out   = dec_q;
  assign bus.err       = err_q;
  assign idxNext       = (idx_q == IDX_W'(OUT_N - 1)) ? '0 : idx_q + 1'b1;

  // Counters hold "cycles left minus one", so a zero count means this is the last cycle.
  always_comb begin
    state_d = state_q;
    dec_d   = dec_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    idx_d   = idx_q;

    if (!bus.en) begin
      state_d = S_IDLE;
      dec_d   = '0;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        S_IDLE, S_LEVEL: begin
          if (bus.mode == MODE_SCAN) begin
            state_d = S_SCAN;
            dec_d   = onehot(0);
            idx_d   = '0;
            cnt_d   = CNT_W'(DWELL - 1);
          end else if (accept) begin
            if (!selInRange) begin
              state_d = S_IDLE;
              dec_d   = '0;
              err_d   = 1'b1;
            end else begin
              dec_d = onehot(int'(bus.sel));
              if (bus.mode == MODE_PULSE) begin
                state_d = S_PULSE;
                cnt_d   = CNT_W'(PULSE_LEN - 1);
              end else begin
                state_d = S_LEVEL;
              end
            end
          end
        end

        S_PULSE: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            state_d = S_IDLE;
            dec_d   = '0;
          end
        end

        S_SCAN: begin
          if (bus.mode != MODE_SCAN) begin
            state_d = S_IDLE;
            dec_d   = '0;
            cnt_d   = '0;
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            idx_d = idxNext;
            dec_d = onehot(int'(idxNext));
            cnt_d = CNT_W'(DWELL - 1);
          end
        end

        default: begin
          state_d = S_IDLE;
          dec_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      dec_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      dec_q   <= dec_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  onehotInvariant: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(dec_q));

endmodule

// File: tb/tb_dec_onehot_seq.sv
// Scoreboard bench for dec_onehot_seq: a channel-level reference model queues the expected
// response per cycle and an independent monitor compares the DUT against it.
module tb_dec_onehot_seq;

  localparam int SEL_W     = 2;
  localparam int OUT_N     = 3;
  localparam int PULSE_LEN = 3;
  localparam int DWELL     = 2;

  typedef struct {
    logic             ready;
    logic [OUT_N-1:0] dec;
    logic             err;
    logic             busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dec_onehot_seq_if #(.SEL_W(SEL_W), .OUT_N(OUT_N)) bus ();

  dec_onehot_seq #(
    .SEL_W(SEL_W), .OUT_N(OUT_N), .PULSE_LEN(PULSE_LEN), .DWELL(DWELL)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  exp_t expQ[$];
  int   assertCount = 0;
  int   failCount   = 0;

  // Reference model: which channel is lit, and how many cycles remain for pulse/dwell.
  int mOn;
  int mPulseRem;
  bit mScanning;
  int mScanPos;
  int mDwellRem;
  bit mErr;

  function automatic void modelReset();
    mOn       = -1;
    mPulseRem = 0;
    mScanning = 1'b0;
    mScanPos  = 0;
    mDwellRem = 0;
    mErr      = 1'b0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    assertCount++;
    if (act !== expv) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic applyStimulus(input bit en, input logic [1:0] mode, input int sel, input bit valid);
    exp_t e;
    bit   rdy;
    @(negedge clk);
    bus.en        = en;
    bus.mode      = mode;
    bus.sel       = SEL_W'(sel);
    bus.sel_valid = valid;

    rdy  = en && (mPulseRem == 0) && !mScanning && (mode != 2'b10);
    mErr = 1'b0;
    if (!en) begin
      mOn       = -1;
      mPulseRem = 0;
      mScanning = 1'b0;
    end else if (mScanning) begin
      if (mode != 2'b10) begin
        mScanning = 1'b0;
        mOn       = -1;
      end else begin
        mDwellRem--;
        if (mDwellRem == 0) begin
          mScanPos  = (mScanPos + 1) % OUT_N;
          mDwellRem = DWELL;
        end
        mOn = mScanPos;
      end
    end else if (mPulseRem > 0) begin
      mPulseRem--;
      if (mPulseRem == 0) mOn = -1;
    end else if (mode == 2'b10) begin
      mScanning = 1'b1;
      mScanPos  = 0;
      mDwellRem = DWELL;
      mOn       = 0;
    end else if (valid) begin
      if (sel >= OUT_N) begin
        mOn  = -1;
        mErr = 1'b1;
      end else begin
        mOn = sel;
        if (mode == 2'b01) mPulseRem = PULSE_LEN;
      end
    end

    e.ready = rdy;
    e.dec   = (mOn < 0) ? '0 : (OUT_N'(1) << mOn);
    e.err   = mErr;
    e.busy  = mScanning || (mPulseRem > 0);
    expQ.push_back(e);
  endtask

  task automatic doAsyncReset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset dec_out", 32'(bus.dec_out), 32'd0);
    checkOutput("async reset busy", 32'(bus.busy), 32'd0);
    checkOutput("async reset err", 32'(bus.err), 32'd0);
    modelReset();
    bus.en        = 1'b0;
    bus.sel_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: sel_ready is checked mid-cycle, registered outputs just after the next edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ[0];
        checkOutput("sel_ready", 32'(bus.sel_ready), 32'(e.ready));
        @(posedge clk);
        #1;
        checkOutput("dec_out", 32'(bus.dec_out), 32'(e.dec));
        checkOutput("err", 32'(bus.err), 32'(e.err));
        checkOutput("busy", 32'(bus.busy), 32'(e.busy));
        void'(expQ.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0] curMode;
    rst_n         = 1'b0;
    bus.en        = 1'b0;
    bus.mode      = 2'b00;
    bus.sel       = '0;
    bus.sel_valid = 1'b0;
    modelReset();
    #2;
    checkOutput("reset dec_out", 32'(bus.dec_out), 32'd0);
    checkOutput("reset err", 32'(bus.err), 32'd0);
    checkOutput("reset busy", 32'(bus.busy), 32'd0);
    checkOutput("reset sel_ready", 32'(bus.sel_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] LEVEL decode and hold");
    applyStimulus(1, 2'b00, 2, 1);
    repeat (3) applyStimulus(1, 2'b00, 1, 0);
    applyStimulus(1, 2'b00, 0, 1);
    applyStimulus(1, 2'b11, 1, 0);
    applyStimulus(1, 2'b11, 1, 1);
    applyStimulus(1, 2'b00, 0, 0);

    $display("[TB] PULSE with mode and valid churn during the pulse");
    applyStimulus(1, 2'b01, 2, 1);
    applyStimulus(1, 2'b10, 0, 1);
    applyStimulus(1, 2'b00, 1, 1);
    applyStimulus(1, 2'b01, 1, 0);
    applyStimulus(1, 2'b00, 0, 0);

    $display("[TB] SCAN wrap then exit");
    repeat (9) applyStimulus(1, 2'b10, 0, 0);
    applyStimulus(1, 2'b00, 0, 0);
    applyStimulus(1, 2'b00, 0, 0);

    $display("[TB] out-of-range select");
    applyStimulus(1, 2'b00, 1, 1);
    applyStimulus(1, 2'b00, 3, 1);
    applyStimulus(1, 2'b01, 3, 1);
    applyStimulus(1, 2'b00, 0, 0);

    $display("[TB] enable dropped mid-PULSE and mid-LEVEL");
    applyStimulus(1, 2'b01, 1, 1);
    applyStimulus(1, 2'b01, 0, 0);
    applyStimulus(0, 2'b00, 2, 1);
    applyStimulus(0, 2'b10, 2, 1);
    applyStimulus(1, 2'b00, 0, 0);
    applyStimulus(1, 2'b00, 1, 1);
    applyStimulus(0, 2'b00, 2, 1);
    applyStimulus(1, 2'b00, 0, 0);

    $display("[TB] asynchronous reset mid-SCAN");
    repeat (3) applyStimulus(1, 2'b10, 0, 0);
    doAsyncReset();

    $display("[TB] randomized traffic");
    curMode = 2'b00;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) curMode = 2'($urandom_range(0, 3));
      applyStimulus($urandom_range(0, 19) != 0, curMode,
                    int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1);
      if (i == 300) doAsyncReset();
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
